datapath: RTL and testbench
===========================

Name: datapath

Overview:
- 32-bit single-bus CPU datapath: sixteen general-purpose registers R0–R15 plus HI, LO, PC, MDR, MAR, IR, Y, Z (64-bit, split Zhigh/Zlow), InPort and CSE.
- All registers exchange data over one shared 32-bit bus.
- The control unit, or a testbench acting as one, drives one-hot "out" selects and "in" load enables.
- A minimal ALU supports AND and PC increment.
- The block sits between memory (Mdatain) and the future control unit.

Parameters:
- WIDTH, 32, bus/register width; all registers are WIDTH bits, Z is 2*WIDTH bits.

Ports:
- clock  input  1  rising-edge clock for every register
- clear  input  1  asynchronous active-high reset of all registers
- R0in..R15in  input  1 each  load enable, GPR n captures bus
- R0out..R15out  input  1 each  GPR n drives bus
- HIin, LOin  input  1 each  HI / LO capture bus
- HIout, LOout  input  1 each  HI / LO drive bus
- Zhighin, Zlowin  input  1 each  capture ALU result high / low half into Z
- Zhighout, Zlowout  input  1 each  Z high / low half drives bus
- PCin, PCout  input  1 each  PC capture / drive
- MDRin, MDRout  input  1 each  MDR capture (from MDR mux) / drive
- MARin, MARout  input  1 each  MAR capture / drive
- InPortin, InPortout  input  1 each  InPort capture / drive
- CSEin, CSEout  input  1 each  CSE capture / drive
- IRin, IRout  input  1 each  IR capture / drive
- IncPC  input  1  ALU op: result = bus + 1
- Mdatain  input  32  memory read data
- MDMuxread  input  1  MDR mux select: 1 = Mdatain, 0 = bus
- Yin  input  1  Y captures bus
- AND  input  1  ALU op: result = Y & bus
- No output ports. The verification engineer observes internal nets hierarchically by these fixed names: r0..r15, hi, lo, zhi, zlo, pc, mdr, mar, ir, y, inport, cse, bus.

Behaviour:
- Reset: clear=1 asynchronously forces every register to 0, including r0..r15, hi, lo, zhi, zlo, pc, mdr, mar, ir, y, inport and cse.
- Clear overrides all load enables while asserted. A mid-operation clear discards that cycle's load.
- Bus is combinational.
  - Driven by the single asserted *out select.
  - Fixed priority if several are asserted (highest first): R0..R15 (lowest index first), HI, LO, Zhigh, Zlow, PC, MDR, MAR, InPort, CSE, IR.
  - Bus = 0 when no out select is asserted.
- Every register loads on the rising clock edge when its enable is high. Value is visible on the bus the cycle after load (1-cycle latency). Enable low holds the value.
- MDR input is Mdatain when MDMuxread=1, otherwise bus.
- CSE captures the sign-extension of bus[18:0] to 32 bits.
- ALU is combinational and produces a 64-bit result C:
  - AND=1: C = {32'b0, y & bus}.
  - else IncPC=1: C = {32'b0, bus + 1}, mod 2^32, so 0xFFFFFFFF wraps to 0.
  - else: C = 0.
  - AND has priority over IncPC.
- Zlowin loads zlo <= C[31:0]. Zhighin loads zhi <= C[63:32]. The two halves load independently.
- Same-edge read-and-write to one register (e.g. Zlowout with Zlowin, or PCout with PCin) stores the new value. The bus carries the old value during that cycle.
- R0 is an ordinary register; no hardwired zero.
- No memory interface beyond Mdatain. MAR is stored only.

Test Plan:
- Reset: pulse clear for 15 ns after preloading registers → all internal registers read 0, bus = 0. Assert clear mid-cycle with R1in=1 → r1 stays 0.
- Register load and AND:
  - Mdatain=0x12 with MDMuxread/MDRin, then MDRout+R2in → r2=0x12.
  - Likewise r3=0x14 and r1=0x18.
  - R2out+Yin, then R3out+AND+Zlowin, then Zlowout+R1in → r1=0x00000010, zhi=0.
- Fetch:
  - From reset, PCout+MARin+IncPC+Zlowin → mar=0, zlo=1.
  - Then Zlowout+PCin with MDMuxread+MDRin and Mdatain=0x28918000 → pc=1, mdr=0x28918000.
  - Then MDRout+IRin → ir=0x28918000.
- Wrap and priority:
  - pc=0xFFFFFFFF, PCout+IncPC+Zlowin → zlo=0.
  - Drive R2out and R3out together → bus = r2.
  - AND and IncPC together → AND result wins.
- CSE: bus=0x00040000, CSEin → cse=0xFFFC0000. bus=0x0003FFFF → cse=0x0003FFFF.
- Holds and MDR mux: all enables low for 5 cycles → no register changes. MDRin with MDMuxread=0 and R1out → mdr=r1.

Source files
------------

// File: rtl/datapath.sv
// Single-bus 32-bit CPU datapath: GPRs, special registers, bus mux and a minimal ALU.
// Every register hangs off one shared combinational bus. A control unit drives the
// one-hot out-selects and the load enables.
module datapath #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             R0in,  input logic R1in,  input logic R2in,  input logic R3in,
  input  logic             R4in,  input logic R5in,  input logic R6in,  input logic R7in,
  input  logic             R8in,  input logic R9in,  input logic R10in, input logic R11in,
  input  logic             R12in, input logic R13in, input logic R14in, input logic R15in,
  input  logic             R0out,  input logic R1out,  input logic R2out,  input logic R3out,
  input  logic             R4out,  input logic R5out,  input logic R6out,  input logic R7out,
  input  logic             R8out,  input logic R9out,  input logic R10out, input logic R11out,
  input  logic             R12out, input logic R13out, input logic R14out, input logic R15out,
  input  logic             HIin,
  input  logic             LOin,
  input  logic             HIout,
  input  logic             LOout,
  input  logic             Zhighin,
  input  logic             Zlowin,
  input  logic             Zhighout,
  input  logic             Zlowout,
  input  logic             PCin,
  input  logic             PCout,
  input  logic             MDRin,
  input  logic             MDRout,
  input  logic             MARin,
  input  logic             MARout,
  input  logic             InPortin,
  input  logic             InPortout,
  input  logic             CSEin,
  input  logic             CSEout,
  input  logic             IRin,
  input  logic             IRout,
  input  logic             IncPC,
  input  logic [WIDTH-1:0] Mdatain,
  input  logic             MDMuxread,
  input  logic             Yin,
  input  logic             AND
);

  logic [15:0]        gpr_load;
  logic [WIDTH-1:0]   gpr [16];
  logic [WIDTH-1:0]   r0, r1, r2, r3, r4, r5, r6, r7;
  logic [WIDTH-1:0]   r8, r9, r10, r11, r12, r13, r14, r15;
  logic [WIDTH-1:0]   hi, lo, zhi, zlo, pc, mdr, mar, ir, y, inport, cse;
  logic [WIDTH-1:0]   bus;
  logic [WIDTH-1:0]   mdr_mux;
  logic [WIDTH-1:0]   cse_ext;
  logic [2*WIDTH-1:0] c;

  assign gpr_load = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                     R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};

  // Named views of the register file so each GPR is observable by name
  assign r0  = gpr[0];  assign r1  = gpr[1];  assign r2  = gpr[2];  assign r3  = gpr[3];
  assign r4  = gpr[4];  assign r5  = gpr[5];  assign r6  = gpr[6];  assign r7  = gpr[7];
  assign r8  = gpr[8];  assign r9  = gpr[9];  assign r10 = gpr[10]; assign r11 = gpr[11];
  assign r12 = gpr[12]; assign r13 = gpr[13]; assign r14 = gpr[14]; assign r15 = gpr[15];

  assign mdr_mux = MDMuxread ? Mdatain : bus;
  assign cse_ext = {{(WIDTH-19){bus[18]}}, bus[18:0]};

  // Bus mux: lowest-priority source assigned first so higher-priority ones overwrite it
  always_comb begin
    bus = '0;
    if (IRout)     bus = ir;
    if (CSEout)    bus = cse;
    if (InPortout) bus = inport;
    if (MARout)    bus = mar;
    if (MDRout)    bus = mdr;
    if (PCout)     bus = pc;
    if (Zlowout)   bus = zlo;
    if (Zhighout)  bus = zhi;
    if (LOout)     bus = lo;
    if (HIout)     bus = hi;
    if (R15out)    bus = r15;
    if (R14out)    bus = r14;
    if (R13out)    bus = r13;
    if (R12out)    bus = r12;
    if (R11out)    bus = r11;
    if (R10out)    bus = r10;
    if (R9out)     bus = r9;
    if (R8out)     bus = r8;
    if (R7out)     bus = r7;
    if (R6out)     bus = r6;
    if (R5out)     bus = r5;
    if (R4out)     bus = r4;
    if (R3out)     bus = r3;
    if (R2out)     bus = r2;
    if (R1out)     bus = r1;
    if (R0out)     bus = r0;
  end

  // ALU: AND takes precedence over increment; upper half is zero for both ops
  always_comb begin
    c = '0;
    if (AND)
      c = {{WIDTH{1'b0}}, y & bus};
    else if (IncPC)
      c = {{WIDTH{1'b0}}, bus + WIDTH'(1)};
  end

  // General-purpose register file, each entry captures the bus on its own enable
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < 16; i++) gpr[i] <= '0;
    end else begin
      for (int i = 0; i < 16; i++)
        if (gpr_load[i]) gpr[i] <= bus;
    end
  end

  // Special registers; Z halves load independently from the ALU result
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      hi     <= '0;
      lo     <= '0;
      zhi    <= '0;
      zlo    <= '0;
      pc     <= '0;
      mdr    <= '0;
      mar    <= '0;
      ir     <= '0;
      y      <= '0;
      inport <= '0;
      cse    <= '0;
    end else begin
      if (HIin)     hi     <= bus;
      if (LOin)     lo     <= bus;
      if (Zhighin)  zhi    <= c[2*WIDTH-1:WIDTH];
      if (Zlowin)   zlo    <= c[WIDTH-1:0];
      if (PCin)     pc     <= bus;
      if (MDRin)    mdr    <= mdr_mux;
      if (MARin)    mar    <= bus;
      if (IRin)     ir     <= bus;
      if (Yin)      y      <= bus;
      if (InPortin) inport <= bus;
      if (CSEin)    cse    <= cse_ext;
    end
  end

endmodule

// File: tb/tb_datapath.sv
// Directed testbench for datapath: stimulus pushes expectations into a scoreboard,
// an independent monitor compares them against internal nets on the falling edge.
module tb_datapath;

  logic        clock = 1'b0;
  logic        clear;
  logic [15:0] rin, rout;
  logic        hi_in, lo_in, hi_out, lo_out, zh_in, zl_in, zh_out, zl_out;
  logic        pc_in, pc_out, mdr_in, mdr_out, mar_in, mar_out, ip_in, ip_out;
  logic        cse_in, cse_out, ir_in, ir_out, inc_pc, md_read, y_in, and_op;
  logic [31:0] mdatain;

  localparam int HI = 16, LO = 17, ZHI = 18, ZLO = 19, PC = 20, MDR = 21, MAR = 22;
  localparam int IR = 23, Y = 24, INPORT = 25, CSE = 26, BUS = 27;

  typedef struct {
    int          id;
    logic [31:0] val;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;

  always #5 clock = ~clock;

  datapath dut (
    .clock(clock), .clear(clear),
    .R0in(rin[0]),   .R1in(rin[1]),   .R2in(rin[2]),   .R3in(rin[3]),
    .R4in(rin[4]),   .R5in(rin[5]),   .R6in(rin[6]),   .R7in(rin[7]),
    .R8in(rin[8]),   .R9in(rin[9]),   .R10in(rin[10]), .R11in(rin[11]),
    .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
    .R0out(rout[0]),   .R1out(rout[1]),   .R2out(rout[2]),   .R3out(rout[3]),
    .R4out(rout[4]),   .R5out(rout[5]),   .R6out(rout[6]),   .R7out(rout[7]),
    .R8out(rout[8]),   .R9out(rout[9]),   .R10out(rout[10]), .R11out(rout[11]),
    .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
    .HIin(hi_in), .LOin(lo_in), .HIout(hi_out), .LOout(lo_out),
    .Zhighin(zh_in), .Zlowin(zl_in), .Zhighout(zh_out), .Zlowout(zl_out),
    .PCin(pc_in), .PCout(pc_out), .MDRin(mdr_in), .MDRout(mdr_out),
    .MARin(mar_in), .MARout(mar_out), .InPortin(ip_in), .InPortout(ip_out),
    .CSEin(cse_in), .CSEout(cse_out), .IRin(ir_in), .IRout(ir_out),
    .IncPC(inc_pc), .Mdatain(mdatain), .MDMuxread(md_read), .Yin(y_in), .AND(and_op)
  );

  function automatic logic [31:0] probe(int id);
    case (id)
      0:  return dut.r0;   1:  return dut.r1;   2:  return dut.r2;   3:  return dut.r3;
      4:  return dut.r4;   5:  return dut.r5;   6:  return dut.r6;   7:  return dut.r7;
      8:  return dut.r8;   9:  return dut.r9;   10: return dut.r10;  11: return dut.r11;
      12: return dut.r12;  13: return dut.r13;  14: return dut.r14;  15: return dut.r15;
      HI:     return dut.hi;
      LO:     return dut.lo;
      ZHI:    return dut.zhi;
      ZLO:    return dut.zlo;
      PC:     return dut.pc;
      MDR:    return dut.mdr;
      MAR:    return dut.mar;
      IR:     return dut.ir;
      Y:      return dut.y;
      INPORT: return dut.inport;
      CSE:    return dut.cse;
      default: return dut.bus;
    endcase
  endfunction

  task automatic idle();
    rin = '0; rout = '0;
    hi_in = 0; lo_in = 0; hi_out = 0; lo_out = 0; zh_in = 0; zl_in = 0; zh_out = 0; zl_out = 0;
    pc_in = 0; pc_out = 0; mdr_in = 0; mdr_out = 0; mar_in = 0; mar_out = 0; ip_in = 0; ip_out = 0;
    cse_in = 0; cse_out = 0; ir_in = 0; ir_out = 0; inc_pc = 0; md_read = 0; y_in = 0; and_op = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic expect_v(int id, logic [31:0] v, string tag);
    exp_t e;
    e.id = id; e.val = v; e.tag = tag;
    sb.push_back(e);
  endtask

  // Wait (bounded) until the monitor has consumed every queued expectation
  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clock);
    if (sb.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL drain: %0d expectations pending, required 0", sb.size());
      sb.delete();
    end
    #1;
  endtask

  task automatic load_mdr(logic [31:0] v);
    mdatain = v; md_read = 1; mdr_in = 1;
    tick();
  endtask

  task automatic mdr_to_r(int n);
    mdr_out = 1; rin[n] = 1;
    tick();
  endtask

  // Monitor: compare queued expectations against the DUT away from the active edge
  initial begin
    exp_t  e;
    logic [31:0] got;
    forever begin
      @(negedge clock);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        got = probe(e.id);
        checks++;
        if (got !== e.val) begin
          fails++;
          $display("FAIL %s: got %08h required %08h", e.tag, got, e.val);
        end else begin
          $display("ok   %s: %08h", e.tag, got);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    mdatain = '0;
    clear = 1;
    repeat (2) @(posedge clock);
    #1;
    clear = 0;
    // Reset state of every observable net
    for (int i = 0; i < 28; i++) expect_v(i, 32'h0, $sformatf("reset_%0d", i));
    drain();

    // Preload then pulse clear for 15 ns
    load_mdr(32'h55);
    mdr_out = 1; rin[1] = 1; rin[5] = 1; hi_in = 1; y_in = 1; pc_in = 1;
    tick();
    expect_v(5, 32'h55, "preload_r5");
    drain();
    clear = 1; #15; clear = 0;
    expect_v(1, 0, "clr_r1"); expect_v(5, 0, "clr_r5"); expect_v(HI, 0, "clr_hi");
    expect_v(Y, 0, "clr_y");  expect_v(PC, 0, "clr_pc"); expect_v(MDR, 0, "clr_mdr");
    expect_v(BUS, 0, "clr_bus");
    drain();

    // Clear asserted mid-cycle with a pending R1 load discards the load
    load_mdr(32'h77);
    mdr_out = 1; rin[1] = 1;
    #2 clear = 1;
    @(posedge clock);
    #1;
    clear = 0;
    idle();
    expect_v(1, 0, "midclr_r1");
    drain();

    // Fetch from reset
    pc_out = 1; mar_in = 1; inc_pc = 1; zl_in = 1;
    tick();
    expect_v(MAR, 0, "fetch_mar"); expect_v(ZLO, 1, "fetch_zlo");
    drain();
    zl_out = 1; pc_in = 1; md_read = 1; mdr_in = 1; mdatain = 32'h28918000;
    tick();
    expect_v(PC, 1, "fetch_pc"); expect_v(MDR, 32'h28918000, "fetch_mdr");
    drain();
    mdr_out = 1; ir_in = 1;
    tick();
    expect_v(IR, 32'h28918000, "fetch_ir");
    drain();

    // Register loads and AND
    load_mdr(32'h12); mdr_to_r(2);
    load_mdr(32'h14); mdr_to_r(3);
    load_mdr(32'h18); mdr_to_r(1);
    expect_v(2, 32'h12, "load_r2"); expect_v(3, 32'h14, "load_r3"); expect_v(1, 32'h18, "load_r1");
    drain();
    rout[2] = 1; y_in = 1; tick();
    rout[3] = 1; and_op = 1; zl_in = 1; zh_in = 1; tick();
    expect_v(ZLO, 32'h10, "and_zlo"); expect_v(ZHI, 0, "and_zhi");
    drain();
    zl_out = 1; rin[1] = 1; tick();
    expect_v(1, 32'h10, "and_r1");
    drain();

    // HI, LO, InPort, R15 loads observed on the bus
    rout[2] = 1; hi_in = 1; tick();
    rout[3] = 1; lo_in = 1; tick();
    rout[1] = 1; ip_in = 1; tick();
    rout[2] = 1; rin[15] = 1; tick();
    hi_out = 1; expect_v(BUS, 32'h12, "bus_hi"); drain(); idle();
    lo_out = 1; expect_v(BUS, 32'h14, "bus_lo"); drain(); idle();
    ip_out = 1; expect_v(BUS, 32'h10, "bus_inport"); drain(); idle();
    rout[15] = 1; expect_v(BUS, 32'h12, "bus_r15"); drain(); idle();
    zh_out = 1; expect_v(BUS, 32'h0, "bus_zhi"); drain(); idle();

    // Increment wrap
    load_mdr(32'hFFFFFFFF);
    mdr_out = 1; pc_in = 1; tick();
    pc_out = 1; inc_pc = 1; zl_in = 1; tick();
    expect_v(ZLO, 32'h0, "wrap_zlo"); expect_v(PC, 32'hFFFFFFFF, "wrap_pc");
    drain();
    // Same-edge read and write of Z low: bus shows old value, register takes new
    zl_out = 1; inc_pc = 1; zl_in = 1;
    expect_v(BUS, 32'h0, "rw_bus_old");
    tick();
    expect_v(ZLO, 32'h1, "rw_zlo_new");
    drain();

    // Bus priority
    rout[2] = 1; rout[3] = 1; expect_v(BUS, 32'h12, "prio_r2_r3"); drain(); idle();
    rout[3] = 1; hi_out = 1;  expect_v(BUS, 32'h14, "prio_r3_hi"); drain(); idle();
    hi_out = 1; lo_out = 1;   expect_v(BUS, 32'h12, "prio_hi_lo"); drain(); idle();
    pc_out = 1; mar_out = 1;  expect_v(BUS, 32'hFFFFFFFF, "prio_pc_mar"); drain(); idle();
    expect_v(BUS, 32'h0, "bus_none"); drain();

    // AND wins over IncPC
    rout[3] = 1; and_op = 1; inc_pc = 1; zl_in = 1; tick();
    expect_v(ZLO, 32'h10, "and_over_inc");
    drain();

    // Sign extension into CSE
    load_mdr(32'h00040000);
    mdr_out = 1; cse_in = 1; tick();
    expect_v(CSE, 32'hFFFC0000, "cse_neg");
    drain();
    load_mdr(32'h0003FFFF);
    mdr_out = 1; cse_in = 1; tick();
    expect_v(CSE, 32'h0003FFFF, "cse_pos");
    drain();

    // Hold: no enables for 5 cycles while memory data changes
    for (int i = 0; i < 5; i++) begin
      md_read = 1; mdatain = 32'hA5A50000 + i;
      @(posedge clock); #1;
    end
    idle();
    expect_v(1, 32'h10, "hold_r1"); expect_v(2, 32'h12, "hold_r2"); expect_v(3, 32'h14, "hold_r3");
    expect_v(15, 32'h12, "hold_r15"); expect_v(HI, 32'h12, "hold_hi"); expect_v(LO, 32'h14, "hold_lo");
    expect_v(INPORT, 32'h10, "hold_inport"); expect_v(PC, 32'hFFFFFFFF, "hold_pc");
    expect_v(MDR, 32'h0003FFFF, "hold_mdr"); expect_v(ZLO, 32'h10, "hold_zlo");
    expect_v(Y, 32'h12, "hold_y"); expect_v(IR, 32'h28918000, "hold_ir"); expect_v(MAR, 0, "hold_mar");
    drain();

    // MDR mux selecting the bus
    rout[1] = 1; mdr_in = 1; md_read = 0; mdatain = 32'hDEADBEEF; tick();
    expect_v(MDR, 32'h10, "mdr_from_bus");
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
